// File: rtl/rc4_session_ctrl_pkg.sv
// Shared definitions for the rc4 session controller: FSM states and parameter defaults.
// Ports: none (package).
// Optional feature macro used elsewhere in this slice: RC4_CTRL_WDOG_EN.
package rc4_session_ctrl_pkg;

  localparam int KEY_MAX_DEF    = 32;
  localparam int FIFO_DEPTH_DEF = 64;
  localparam int ENC_LAT_DEF    = 2;
  localparam int WDOG_CYC_DEF   = 4096;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FILL,
    ST_START,
    ST_KEYWAIT,
    ST_KEYXFER,
    ST_PTWAIT,
    ST_PTXFER,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Length is legal when in 1..max; both arguments zero-extended by the caller.
  function automatic logic len_ok(input logic [15:0] len, input logic [15:0] max);
    return (len != 16'd0) && (len <= max);
  endfunction

endpackage

// File: rtl/rc4_session_ctrl_fifo.sv
// rc4_byte_fifo: 8-bit synchronous first-word-fall-through FIFO with occupancy count and flush.
// Ports: clk_i/rst_ni, flush_i, wr_i/wr_dat_i, rd_i/rd_dat_o, full_o/empty_o, cnt_o.
// Writes when full and reads when empty are dropped; flush_i beats a same-cycle write/read.
module rc4_byte_fifo #(
  parameter int DEPTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic                   wr_i,
  input  logic [7:0]             wr_dat_i,
  input  logic                   rd_i,
  output logic [7:0]             rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_wr, do_rd;

  assign full_o   = (cnt_q == FULL_CNT);
  assign empty_o  = (cnt_q == '0);
  assign cnt_o    = cnt_q;
  assign rd_dat_o = mem_q[rd_ptr_q];
  assign do_wr    = wr_i & ~full_o & ~flush_i;
  assign do_rd    = rd_i & ~empty_o & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
  end

endmodule

// File: rtl/rc4_session_ctrl.sv
// rc4_session_ctrl: buffers key and plaintext, runs one rc4 core burst per session, captures ciphertext.
// Ports: host key bus (KEY_*), GO/ABORT, PT and CT valid/ready streams, status, rc4 core interface.
// Optional watchdog on KEYWAIT/PTWAIT/DRAIN enabled by macro RC4_CTRL_WDOG_EN.
module rc4_session_ctrl
  import rc4_session_ctrl_pkg::*;
#(
  parameter int KEY_MAX    = KEY_MAX_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ENC_LAT    = ENC_LAT_DEF,
  parameter int WDOG_CYC   = WDOG_CYC_DEF
) (
  input  logic                        CLK_IN,
  input  logic                        RESET_N_IN,
  input  logic                        KEY_WR_IN,
  input  logic [7:0]                  KEY_ADDR_IN,
  input  logic [7:0]                  KEY_DATA_IN,
  input  logic [8:0]                  KEY_LEN_IN,
  input  logic [$clog2(FIFO_DEPTH):0] MSG_LEN_IN,
  input  logic                        GO_IN,
  input  logic                        ABORT_IN,
  input  logic                        PT_VALID_IN,
  output logic                        PT_READY_OUT,
  input  logic [7:0]                  PT_DATA_IN,
  output logic                        CT_VALID_OUT,
  input  logic                        CT_READY_IN,
  output logic [7:0]                  CT_DATA_OUT,
  output logic                        BUSY_OUT,
  output logic                        DONE_OUT,
  output logic                        ERR_OUT,
  output logic [8:0]                  RC4_KEY_SIZE_OUT,
  output logic [7:0]                  RC4_KEY_BYTE_OUT,
  output logic [7:0]                  RC4_PLAIN_BYTE_OUT,
  output logic                        RC4_START_OUT,
  output logic                        RC4_STOP_OUT,
  output logic                        RC4_HOLD_OUT,
  input  logic                        RC4_START_KEY_CPY_IN,
  input  logic                        RC4_BUSY_IN,
  input  logic                        RC4_READ_PLAINTEXT_IN,
  input  logic [7:0]                  RC4_ENC_BYTE_IN
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int KAW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [8:0]    KEY_MAX_C = 9'(KEY_MAX);
  localparam logic [7:0]    ENC_LAT_C = 8'(ENC_LAT);

  state_t        state_q, state_d;
  logic [8:0]    key_len_q, key_len_d, key_idx_q, key_idx_d;
  logic [CW-1:0] msg_len_q, msg_len_d, pt_idx_q, pt_idx_d, cap_cnt_q, cap_cnt_d;
  logic [7:0]    key_byte_q, key_byte_d, plain_byte_q, plain_byte_d;
  logic [7:0]    cap_lat_q, cap_lat_d;
  logic          cap_act_q, cap_act_d, err_q, err_d, stop_q, stop_d;
  logic          pt_pop, ct_push, flush, pt_full, wdog_hit, key_wr_en;
  logic [7:0]    pt_rd_dat, key_mem [KEY_MAX];
  logic [CW-1:0] pt_cnt, ct_cnt, ct_free;
  logic          ct_empty, unused_pt_empty, unused_ct_full, unused_rc4_busy;

  assign unused_rc4_busy = RC4_BUSY_IN;

  rc4_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_pt_fifo (
    .clk_i(CLK_IN), .rst_ni(RESET_N_IN), .flush_i(flush),
    .wr_i(PT_VALID_IN), .wr_dat_i(PT_DATA_IN), .rd_i(pt_pop), .rd_dat_o(pt_rd_dat),
    .full_o(pt_full), .empty_o(unused_pt_empty), .cnt_o(pt_cnt)
  );

  rc4_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_ct_fifo (
    .clk_i(CLK_IN), .rst_ni(RESET_N_IN), .flush_i(flush),
    .wr_i(ct_push), .wr_dat_i(RC4_ENC_BYTE_IN), .rd_i(CT_READY_IN), .rd_dat_o(CT_DATA_OUT),
    .full_o(unused_ct_full), .empty_o(ct_empty), .cnt_o(ct_cnt)
  );

  assign ct_free = DEPTH_C - ct_cnt;

  // Key buffer is only writable between sessions so a running burst sees a stable key.
  assign key_wr_en = KEY_WR_IN && (state_q == ST_IDLE) && ({1'b0, KEY_ADDR_IN} < KEY_MAX_C);

  always_ff @(posedge CLK_IN) begin
    if (key_wr_en) key_mem[KEY_ADDR_IN[KAW-1:0]] <= KEY_DATA_IN;
  end

`ifdef RC4_CTRL_WDOG_EN
  logic [31:0] wdog_q;

  assign wdog_hit = (state_q inside {ST_KEYWAIT, ST_PTWAIT, ST_DRAIN}) &&
                    (wdog_q == 32'(WDOG_CYC - 1));

  // Counts consecutive cycles spent in one waiting state; restarts on any state change.
  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN)
      wdog_q <= '0;
    else if ((state_d != state_q) || !(state_q inside {ST_KEYWAIT, ST_PTWAIT, ST_DRAIN}))
      wdog_q <= '0;
    else
      wdog_q <= wdog_q + 32'd1;
  end
`else
  assign wdog_hit = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    key_len_d    = key_len_q;
    msg_len_d    = msg_len_q;
    key_idx_d    = key_idx_q;
    pt_idx_d     = pt_idx_q;
    key_byte_d   = key_byte_q;
    plain_byte_d = plain_byte_q;
    cap_act_d    = cap_act_q;
    cap_lat_d    = cap_lat_q;
    cap_cnt_d    = cap_cnt_q;
    err_d        = 1'b0;
    stop_d       = 1'b0;
    pt_pop       = 1'b0;
    ct_push      = 1'b0;
    flush        = 1'b0;

    // Capture window: cap_lat_q is the number of edges since the READ_PLAINTEXT sample edge.
    if (cap_act_q) begin
      if (cap_lat_q != 8'hFF) cap_lat_d = cap_lat_q + 8'd1;
      if (cap_lat_q >= ENC_LAT_C) begin
        ct_push   = 1'b1;
        cap_cnt_d = cap_cnt_q + ONE_C;
        if (cap_cnt_q + ONE_C == msg_len_q) cap_act_d = 1'b0;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (GO_IN && !ABORT_IN) begin
          if (len_ok(16'(KEY_LEN_IN), 16'(KEY_MAX)) && len_ok(16'(MSG_LEN_IN), 16'(FIFO_DEPTH))) begin
            key_len_d = KEY_LEN_IN;
            msg_len_d = MSG_LEN_IN;
            state_d   = ST_FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      // Whole message buffered and CT space reserved, so the burst can never stall.
      ST_FILL: if (pt_cnt >= msg_len_q && ct_free >= msg_len_q) state_d = ST_START;
      ST_START: state_d = ST_KEYWAIT;
      ST_KEYWAIT: begin
        if (RC4_START_KEY_CPY_IN) begin
          key_byte_d = key_mem[0];
          key_idx_d  = 9'd1;
          state_d    = ST_KEYXFER;
        end
      end
      ST_KEYXFER: begin
        if (key_idx_q < key_len_q) begin
          key_byte_d = key_mem[key_idx_q[KAW-1:0]];
          key_idx_d  = key_idx_q + 9'd1;
        end else begin
          key_byte_d = 8'h00;
          state_d    = ST_PTWAIT;
        end
      end
      ST_PTWAIT: begin
        if (RC4_READ_PLAINTEXT_IN) begin
          plain_byte_d = pt_rd_dat;
          pt_pop       = 1'b1;
          pt_idx_d     = ONE_C;
          cap_act_d    = 1'b1;
          cap_lat_d    = 8'd1;
          cap_cnt_d    = '0;
          state_d      = ST_PTXFER;
        end
      end
      ST_PTXFER: begin
        if (pt_idx_q < msg_len_q) begin
          plain_byte_d = pt_rd_dat;
          pt_pop       = 1'b1;
          pt_idx_d     = pt_idx_q + ONE_C;
        end else begin
          plain_byte_d = 8'h00;
          state_d      = ST_DRAIN;
        end
      end
      ST_DRAIN: if (!cap_act_q && cap_cnt_q == msg_len_q) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Abort (or watchdog expiry) overrides everything the session was doing this cycle.
    if ((ABORT_IN || wdog_hit) && state_q != ST_IDLE) begin
      state_d      = ST_IDLE;
      stop_d       = 1'b1;
      err_d        = wdog_hit;
      flush        = 1'b1;
      pt_pop       = 1'b0;
      ct_push      = 1'b0;
      cap_act_d    = 1'b0;
      key_byte_d   = 8'h00;
      plain_byte_d = 8'h00;
    end
  end

  always_ff @(posedge CLK_IN or negedge RESET_N_IN) begin
    if (!RESET_N_IN) begin
      state_q      <= ST_IDLE;
      key_len_q    <= '0;
      msg_len_q    <= '0;
      key_idx_q    <= '0;
      pt_idx_q     <= '0;
      key_byte_q   <= '0;
      plain_byte_q <= '0;
      cap_act_q    <= 1'b0;
      cap_lat_q    <= '0;
      cap_cnt_q    <= '0;
      err_q        <= 1'b0;
      stop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_len_q    <= key_len_d;
      msg_len_q    <= msg_len_d;
      key_idx_q    <= key_idx_d;
      pt_idx_q     <= pt_idx_d;
      key_byte_q   <= key_byte_d;
      plain_byte_q <= plain_byte_d;
      cap_act_q    <= cap_act_d;
      cap_lat_q    <= cap_lat_d;
      cap_cnt_q    <= cap_cnt_d;
      err_q        <= err_d;
      stop_q       <= stop_d;
    end
  end

  assign PT_READY_OUT       = ~pt_full;
  assign CT_VALID_OUT       = ~ct_empty;
  assign BUSY_OUT           = (state_q != ST_IDLE);
  assign DONE_OUT           = (state_q == ST_DONE);
  assign ERR_OUT            = err_q;
  assign RC4_KEY_SIZE_OUT   = key_len_q;
  assign RC4_KEY_BYTE_OUT   = key_byte_q;
  assign RC4_PLAIN_BYTE_OUT = plain_byte_q;
  assign RC4_START_OUT      = (state_q == ST_START);
  assign RC4_STOP_OUT       = stop_q;
  assign RC4_HOLD_OUT       = 1'b0;

endmodule

// File: tb/tb_rc4_session_ctrl.sv
module tb_rc4_session_ctrl;

  localparam int KEY_MAX    = 32;
  localparam int FIFO_DEPTH = 64;
  localparam int ENC_LAT    = 2;
  localparam int WDOG_CYC   = 4096;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_wr, go, abort, pt_vld, pt_rdy, ct_vld, ct_rdy;
  logic [7:0] key_addr, key_data, pt_dat, ct_dat;
  logic [8:0] key_len, key_size;
  logic [6:0] msg_len;
  logic       busy, done, err, r_start, r_stop, r_hold, skc, rbusy, rpt;
  logic [7:0] key_byte, plain_byte, enc;

  logic [7:0] key [32];
  logic [7:0] pt  [32];
  logic [7:0] ct_exp [32];
  logic [255:0] key_v, pt_v;
  logic [7:0] prev_plain;
  bit         seen, started;
  int         errors = 0;
  int         checks = 0;

  always #5 clk = ~clk;

  rc4_session_ctrl #(
    .KEY_MAX(KEY_MAX), .FIFO_DEPTH(FIFO_DEPTH), .ENC_LAT(ENC_LAT), .WDOG_CYC(WDOG_CYC)
  ) dut (
    .CLK_IN(clk), .RESET_N_IN(rst_n),
    .KEY_WR_IN(key_wr), .KEY_ADDR_IN(key_addr), .KEY_DATA_IN(key_data),
    .KEY_LEN_IN(key_len), .MSG_LEN_IN(msg_len), .GO_IN(go), .ABORT_IN(abort),
    .PT_VALID_IN(pt_vld), .PT_READY_OUT(pt_rdy), .PT_DATA_IN(pt_dat),
    .CT_VALID_OUT(ct_vld), .CT_READY_IN(ct_rdy), .CT_DATA_OUT(ct_dat),
    .BUSY_OUT(busy), .DONE_OUT(done), .ERR_OUT(err),
    .RC4_KEY_SIZE_OUT(key_size), .RC4_KEY_BYTE_OUT(key_byte), .RC4_PLAIN_BYTE_OUT(plain_byte),
    .RC4_START_OUT(r_start), .RC4_STOP_OUT(r_stop), .RC4_HOLD_OUT(r_hold),
    .RC4_START_KEY_CPY_IN(skc), .RC4_BUSY_IN(rbusy), .RC4_READ_PLAINTEXT_IN(rpt),
    .RC4_ENC_BYTE_IN(enc)
  );

  // Keystream of the stand-in core: arbitrary but fixed per byte index.
  function automatic logic [7:0] ks(input int k);
    return 8'(k * 37 + 11);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // which: 0 = RC4_START, 1 = DONE, 2 = ERR; checks from the next falling edge on.
  task automatic wait_sig(input int which, input int budget, output bit hit);
    hit = 1'b0;
    for (int n = 0; n < budget && !hit; n++) begin
      @(negedge clk);
      case (which)
        0:       hit = r_start;
        1:       hit = done;
        default: hit = err;
      endcase
    end
  endtask

  task automatic push_pt(input logic [7:0] d);
    pt_vld = 1'b1;
    pt_dat = d;
    @(negedge clk);
    pt_vld = 1'b0;
  endtask

  task automatic pulse_go(input logic [8:0] kl, input logic [6:0] ml, input logic ab);
    key_len = kl;
    msg_len = ml;
    go      = 1'b1;
    abort   = ab;
    @(negedge clk);
    go    = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    key_v = 256'hae6c3c41_884b1e22_39a7c0d3_5f1296e8_07bd44a1_c36e9f58_2d71e00b_1e5ab405;
    pt_v  = 256'h3ae280d0_61c4f5a2_9b0e7d13_48aa36f1_d5087c9e_2b63e1b4_7f19c028_f287c595;
    for (int i = 0; i < 32; i++) begin
      key[i]    = key_v[255 - 8*i -: 8];
      pt[i]     = pt_v[255 - 8*i -: 8];
      ct_exp[i] = pt[i] ^ ks(i);
    end

    rst_n = 1'b0; key_wr = 1'b0; key_addr = '0; key_data = '0; key_len = '0; msg_len = '0;
    go = 1'b0; abort = 1'b0; pt_vld = 1'b0; pt_dat = '0; ct_rdy = 1'b0;
    skc = 1'b0; rbusy = 1'b0; rpt = 1'b0; enc = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_ct_vld", ct_vld, 0);
    chk("rst_start", r_start, 0);
    chk("rst_stop", r_stop, 0);
    chk("rst_key_size", key_size, 0);
    chk("rst_hold", r_hold, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_pt_rdy", pt_rdy, 1);

    // Session 1: full 32-byte key and message, prefilled before GO.
    for (int i = 0; i < 32; i++) begin
      key_wr = 1'b1; key_addr = 8'(i); key_data = key[i];
      @(negedge clk);
    end
    key_wr = 1'b0;
    for (int i = 0; i < 32; i++) push_pt(pt[i]);
    pulse_go(9'd32, 7'd32, 1'b0);
    chk("s1_busy", busy, 1);
    chk("s1_key_size", key_size, 32);
    wait_sig(0, 20, seen);
    chk("s1_start_seen", seen, 1);
    @(negedge clk);
    chk("s1_start_one_cycle", r_start, 0);

    skc = 1'b1;
    @(negedge clk);
    skc = 1'b0;
    for (int i = 0; i <= 32; i++) begin
      chk($sformatf("s1_key_byte%0d", i), key_byte, (i < 32) ? key[i] : 8'h00);
      @(negedge clk);
    end

    rpt = 1'b1;
    prev_plain = 8'h00;
    for (int j = 0; j <= 33; j++) begin
      @(negedge clk);
      if (j == 0) rpt = 1'b0;
      if (j <= 32) chk($sformatf("s1_plain%0d", j), plain_byte, (j < 32) ? pt[j] : 8'h00);
      enc = prev_plain ^ ks(j - 1);
      prev_plain = plain_byte;
    end
    wait_sig(1, 50, seen);
    chk("s1_done_seen", seen, 1);
    @(negedge clk);
    chk("s1_done_one_cycle", done, 0);
    chk("s1_idle_busy", busy, 0);
    chk("s1_no_err", err, 0);

    // Drain ciphertext with a 100-cycle stall halfway through.
    for (int k = 0; k < 32; k++) begin
      if (k == 16) begin
        ct_rdy = 1'b0;
        repeat (100) @(negedge clk);
      end
      chk($sformatf("s1_ct_vld%0d", k), ct_vld, 1);
      chk($sformatf("s1_ct%0d", k), ct_dat, ct_exp[k]);
      ct_rdy = 1'b1;
      @(negedge clk);
    end
    ct_rdy = 1'b0;
    chk("s1_ct_empty", ct_vld, 0);

    // Session 2: GO with 31 of 32 bytes present must hold in FILL.
    for (int i = 0; i < 31; i++) push_pt(pt[i]);
    pulse_go(9'd32, 7'd32, 1'b0);
    started = 1'b0;
    repeat (10) begin
      @(negedge clk);
      started |= r_start;
    end
    chk("s2_no_start_early", started, 0);
    chk("s2_busy_fill", busy, 1);
    push_pt(pt[31]);
    wait_sig(0, 10, seen);
    chk("s2_start_after_last", seen, 1);

    // Abort in PTXFER.
    @(negedge clk);
    skc = 1'b1;
    @(negedge clk);
    skc = 1'b0;
    repeat (40) @(negedge clk);
    rpt = 1'b1;
    @(negedge clk);
    rpt = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab_stop", r_stop, 1);
    chk("ab_busy", busy, 0);
    chk("ab_ct_vld", ct_vld, 0);
    @(negedge clk);
    chk("ab_stop_one_cycle", r_stop, 0);
    chk("ab_pt_rdy", pt_rdy, 1);
    chk("ab_plain_zero", plain_byte, 0);

    // PT FIFO must be empty after abort: a 4-byte GO with nothing written cannot start.
    pulse_go(9'd4, 7'd4, 1'b0);
    started = 1'b0;
    repeat (8) begin
      @(negedge clk);
      started |= r_start;
    end
    chk("ab_pt_flushed", started, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("ab2_stop", r_stop, 1);
    chk("ab2_busy", busy, 0);
    @(negedge clk);

    // Parameter errors and GO/ABORT collision in IDLE.
    pulse_go(9'd0, 7'd4, 1'b0);
    chk("err_keylen0", err, 1);
    chk("err_keylen0_idle", busy, 0);
    @(negedge clk);
    chk("err_one_cycle", err, 0);
    pulse_go(9'd4, 7'd65, 1'b0);
    chk("err_msglen65", err, 1);
    chk("err_msglen65_idle", busy, 0);
    pulse_go(9'd33, 7'd4, 1'b0);
    chk("err_keylen33", err, 1);
    pulse_go(9'd4, 7'd4, 1'b1);
    chk("goabort_busy", busy, 0);
    chk("goabort_err", err, 0);
    chk("goabort_stop", r_stop, 0);

`ifdef RC4_CTRL_WDOG_EN
    // Core never asserts START_KEY_CPY: watchdog aborts with an error pulse.
    for (int i = 0; i < 4; i++) push_pt(pt[i]);
    pulse_go(9'd4, 7'd4, 1'b0);
    wait_sig(0, 10, seen);
    chk("wd_start", seen, 1);
    wait_sig(2, WDOG_CYC + 20, seen);
    chk("wd_err", seen, 1);
    chk("wd_stop", r_stop, 1);
    chk("wd_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
